// File: rtl/multi_cycle_ctrl.sv
// Moore controller for the multi-cycle MIPS datapath.
// It sequences R-type, lw, sw, beq, addi and j instructions and stalls on mem_ready.
// It also flags unsupported opcodes and counts retired instructions.
module multi_cycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_RST    = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t st;

  function automatic logic op_legal(input logic [5:0] o);
    return (o == OP_R) || (o == OP_LW) || (o == OP_SW) ||
           (o == OP_BEQ) || (o == OP_ADDI) || (o == OP_J);
  endfunction

  assign state = st;

  // State sequencing, illegal-opcode pulse and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_RST;
      illegal_op <= 1'b0;
      retired    <= '0;
    end else begin
      illegal_op <= (st == S_DECODE) && !op_legal(op);
      if (instr_done) retired <= retired + CNT_ONE;
      case (st)
        S_RST:    st <= S_FETCH;
        S_FETCH:  st <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: st <= S_MEMADR;
            OP_R:         st <= S_EXEC;
            OP_BEQ:       st <= S_BEQ;
            OP_ADDI:      st <= S_ADDIEX;
            OP_J:         st <= S_JUMP;
            default:      st <= S_FETCH;
          endcase
        end
        // op is looked at again here to pick the load or store path
        S_MEMADR: begin
          if (op == OP_LW)      st <= S_MEMRD;
          else if (op == OP_SW) st <= S_MEMWR;
          else                  st <= S_FETCH;
        end
        S_MEMRD:  st <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWB:  st <= S_FETCH;
        S_MEMWR:  st <= mem_ready ? S_FETCH : S_MEMWR;
        S_EXEC:   st <= S_RWB;
        S_RWB:    st <= S_FETCH;
        S_BEQ:    st <= S_FETCH;
        S_JUMP:   st <= S_FETCH;
        S_ADDIEX: st <= S_ADDIWB;
        S_ADDIWB: st <= S_FETCH;
        default:  st <= S_FETCH;
      endcase
    end
  end

  // Datapath controls are decoded from the state alone
  // Exceptions: ir_write/pc_write in FETCH and the store's instr_done are gated by mem_ready
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    instr_done    = 1'b0;
    case (st)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed table-driven bench for multi_cycle_ctrl.
// A 32-bit counter instance and a 2-bit counter instance share the same stimulus.
module tb_multi_cycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  op;
  logic        mem_ready;

  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] retired;

  logic        b_pc_write, b_pc_write_cond, b_i_or_d, b_mem_read, b_mem_write, b_ir_write;
  logic        b_reg_dst, b_mem_to_reg, b_reg_write, b_alu_src_a, b_instr_done, b_illegal_op;
  logic [1:0]  b_pc_source, b_alu_src_b, b_alu_op;
  logic [3:0]  b_state;
  logic [1:0]  retired2;

  // Control bit order: pcw pcwc pcs[1:0] iord mrd mwr irw rdst m2r rw asa asb[1:0] aop[1:0]
  logic [15:0] ctl;
  assign ctl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
    .instr_done(instr_done), .illegal_op(illegal_op), .retired(retired)
  );

  multi_cycle_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .pc_source(b_pc_source),
    .i_or_d(b_i_or_d), .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .state(b_state),
    .instr_done(b_instr_done), .illegal_op(b_illegal_op), .retired(retired2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        done;
    logic        ill;
  } vec_t;

  // Hand-derived control words per state
  localparam logic [15:0] C_F1 = 16'h8504;  // FETCH, mem_ready=1
  localparam logic [15:0] C_F0 = 16'h0404;  // FETCH, mem_ready=0
  localparam logic [15:0] C_DE = 16'h000C;
  localparam logic [15:0] C_MA = 16'h0018;
  localparam logic [15:0] C_MR = 16'h0C00;
  localparam logic [15:0] C_MB = 16'h0060;
  localparam logic [15:0] C_MW = 16'h0A00;
  localparam logic [15:0] C_EX = 16'h0012;
  localparam logic [15:0] C_RW = 16'h00A0;
  localparam logic [15:0] C_BQ = 16'h5011;
  localparam logic [15:0] C_JP = 16'hA000;
  localparam logic [15:0] C_AE = 16'h0018;
  localparam logic [15:0] C_AW = 16'h0020;

  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BQ = 6'h04, AD = 6'h08, J = 6'h02, IL = 6'h3F;

  vec_t        tbl[$];
  int          nvec;
  int          nerr;
  logic [31:0] exp_ret;

  task automatic check(input string nm, input logic ok, input string act, input string req);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %s, expected %s", nm, act, req);
    end
  endtask

  task automatic run_row(input string nm, input vec_t v);
    logic ok;
    @(negedge clk);
    op = v.op;
    mem_ready = v.rdy;
    #1;
    ok = (state === v.st) && (ctl === v.ctl) && (instr_done === v.done) &&
         (illegal_op === v.ill) && (retired === exp_ret) && (retired2 === exp_ret[1:0]);
    check(nm, ok,
          $sformatf("st=%0d ctl=%h done=%b ill=%b ret=%0d ret2=%0d", state, ctl, instr_done, illegal_op, retired, retired2),
          $sformatf("st=%0d ctl=%h done=%b ill=%b ret=%0d ret2=%0d", v.st, v.ctl, v.done, v.ill, exp_ret, exp_ret[1:0]));
    if (v.done) exp_ret = exp_ret + 32'd1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    exp_ret = 32'd0;
    rst_n = 1'b0;
    op = 6'h00;
    mem_ready = 1'b1;

    // R-type
    tbl.push_back('{R, 1'b1, 4'd0, C_F1, 1'b0, 1'b0});
    tbl.push_back('{R, 1'b1, 4'd1, C_DE, 1'b0, 1'b0});
    tbl.push_back('{R, 1'b1, 4'd6, C_EX, 1'b0, 1'b0});
    tbl.push_back('{R, 1'b1, 4'd7, C_RW, 1'b1, 1'b0});
    // lw with 3 stall cycles in MEMRD
    tbl.push_back('{LW, 1'b1, 4'd0, C_F1, 1'b0, 1'b0});
    tbl.push_back('{LW, 1'b1, 4'd1, C_DE, 1'b0, 1'b0});
    tbl.push_back('{LW, 1'b1, 4'd2, C_MA, 1'b0, 1'b0});
    tbl.push_back('{LW, 1'b0, 4'd3, C_MR, 1'b0, 1'b0});
    tbl.push_back('{LW, 1'b0, 4'd3, C_MR, 1'b0, 1'b0});
    tbl.push_back('{LW, 1'b0, 4'd3, C_MR, 1'b0, 1'b0});
    tbl.push_back('{LW, 1'b1, 4'd3, C_MR, 1'b0, 1'b0});
    tbl.push_back('{LW, 1'b1, 4'd4, C_MB, 1'b1, 1'b0});
    // sw with one stall in MEMWR
    tbl.push_back('{SW, 1'b1, 4'd0, C_F1, 1'b0, 1'b0});
    tbl.push_back('{SW, 1'b1, 4'd1, C_DE, 1'b0, 1'b0});
    tbl.push_back('{SW, 1'b1, 4'd2, C_MA, 1'b0, 1'b0});
    tbl.push_back('{SW, 1'b0, 4'd5, C_MW, 1'b0, 1'b0});
    tbl.push_back('{SW, 1'b1, 4'd5, C_MW, 1'b1, 1'b0});
    // beq
    tbl.push_back('{BQ, 1'b1, 4'd0, C_F1, 1'b0, 1'b0});
    tbl.push_back('{BQ, 1'b1, 4'd1, C_DE, 1'b0, 1'b0});
    tbl.push_back('{BQ, 1'b1, 4'd8, C_BQ, 1'b1, 1'b0});
    // j
    tbl.push_back('{J, 1'b1, 4'd0, C_F1, 1'b0, 1'b0});
    tbl.push_back('{J, 1'b1, 4'd1, C_DE, 1'b0, 1'b0});
    tbl.push_back('{J, 1'b1, 4'd9, C_JP, 1'b1, 1'b0});
    // addi
    tbl.push_back('{AD, 1'b1, 4'd0, C_F1, 1'b0, 1'b0});
    tbl.push_back('{AD, 1'b1, 4'd1, C_DE, 1'b0, 1'b0});
    tbl.push_back('{AD, 1'b1, 4'd10, C_AE, 1'b0, 1'b0});
    tbl.push_back('{AD, 1'b1, 4'd11, C_AW, 1'b1, 1'b0});
    // illegal opcode, then a FETCH stall, then j
    tbl.push_back('{IL, 1'b1, 4'd0, C_F1, 1'b0, 1'b0});
    tbl.push_back('{IL, 1'b1, 4'd1, C_DE, 1'b0, 1'b0});
    tbl.push_back('{J, 1'b0, 4'd0, C_F0, 1'b0, 1'b1});
    tbl.push_back('{J, 1'b1, 4'd0, C_F1, 1'b0, 1'b0});
    tbl.push_back('{J, 1'b1, 4'd1, C_DE, 1'b0, 1'b0});
    tbl.push_back('{J, 1'b1, 4'd9, C_JP, 1'b1, 1'b0});

    // Reset held: RST state, all controls low
    repeat (2) @(negedge clk);
    #1;
    check("reset_hold", (state === 4'd15) && (ctl === 16'h0000) && (instr_done === 1'b0) &&
          (illegal_op === 1'b0) && (retired === 32'd0) && (retired2 === 2'd0),
          $sformatf("st=%0d ctl=%h done=%b ill=%b ret=%0d", state, ctl, instr_done, illegal_op, retired),
          "st=15 ctl=0000 done=0 ill=0 ret=0");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release", (state === 4'd15) && (ctl === 16'h0000),
          $sformatf("st=%0d ctl=%h", state, ctl), "st=15 ctl=0000");

    foreach (tbl[i]) run_row($sformatf("vec%0d", i), tbl[i]);

    // Asynchronous reset in the middle of a stalled store
    run_row("mr_fetch",  '{SW, 1'b1, 4'd0, C_F1, 1'b0, 1'b0});
    run_row("mr_decode", '{SW, 1'b1, 4'd1, C_DE, 1'b0, 1'b0});
    run_row("mr_memadr", '{SW, 1'b1, 4'd2, C_MA, 1'b0, 1'b0});
    run_row("mr_memwr",  '{SW, 1'b0, 4'd5, C_MW, 1'b0, 1'b0});
    #1 rst_n = 1'b0;
    #1;
    check("async_rst", (mem_write === 1'b0) && (state === 4'd15) && (instr_done === 1'b0) &&
          (retired === 32'd0) && (retired2 === 2'd0),
          $sformatf("mwr=%b st=%0d done=%b ret=%0d ret2=%0d", mem_write, state, instr_done, retired, retired2),
          "mwr=0 st=15 done=0 ret=0 ret2=0");
    exp_ret = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // Five jumps: the 2-bit counter wraps to 1
    for (int k = 0; k < 5; k++) begin
      run_row($sformatf("wrap_f%0d", k), '{J, 1'b1, 4'd0, C_F1, 1'b0, 1'b0});
      run_row($sformatf("wrap_d%0d", k), '{J, 1'b1, 4'd1, C_DE, 1'b0, 1'b0});
      run_row($sformatf("wrap_j%0d", k), '{J, 1'b1, 4'd9, C_JP, 1'b1, 1'b0});
    end
    @(negedge clk);
    #1;
    check("wrap_count", (retired === 32'd5) && (retired2 === 2'd1) && (state === 4'd0),
          $sformatf("ret=%0d ret2=%0d st=%0d", retired, retired2, state), "ret=5 ret2=1 st=0");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
